// File: rtl/rom_fifo_filler.sv
`default_nettype none
// ============================================================================
//  Module   : rom_fifo_filler
//  Brief    : Write-side producer for the camera-to-SDRAM desk FIFO. Scans a
//             pattern ROM by row/column and issues fixed-length read bursts
//             whenever the FIFO fill level is below a low-water mark. The
//             FIFO write request is the ROM read strobe delayed by the ROM
//             latency, so it lines up with the ROM data at the FIFO.
//  Option   : ROM_FRAME_STOP_EN - stop after each frame, re-arm on an
//             en_i rising edge (undefined: continuous looping).
//  Revision : 1.0 - initial release
// ============================================================================
module rom_fifo_filler #(
    parameter int H_ACT     = 256,   // columns per line (1..256)
    parameter int V_ACT     = 256,   // lines per frame (1..256)
    parameter int BURST_LEN = 255,   // ROM reads per burst (1..255)
    parameter int FIFO_LOW  = 512,   // burst starts only below this level
    parameter int ROM_LAT   = 1,     // ROM read latency (1..3)
    parameter int CLEAR_CYC = 8      // cycles spent in CLEAR (2..15)
) (
    input  logic        clk_100M_i,
    input  logic        rst_100i,
    input  logic        en_i,
    input  logic [10:0] fifo_used_i,
    input  logic [2:0]  rom_dat_i,
    output logic [15:0] rdrom_add_o,
    output logic [2:0]  fifo_dat_o,
    output logic        wr_fifo_o,
    output logic        busy_o,
    output logic        frame_done_o
);

    localparam logic [7:0]  c_col_last   = 8'(H_ACT - 1);
    localparam logic [7:0]  c_row_last   = 8'(V_ACT - 1);
    localparam logic [7:0]  c_burst_last = 8'(BURST_LEN - 1);
    localparam logic [3:0]  c_clear_last = 4'(CLEAR_CYC - 1);
    localparam logic [10:0] c_fifo_low   = 11'(FIFO_LOW);

    typedef enum logic [1:0] {
        CLEAR   = 2'b00,
        IDLE    = 2'b01,
        WR_FIFO = 2'b10,
        NONE2   = 2'b11
    } state_t;

    state_t             state_q;
    logic [7:0]         col_q;
    logic [7:0]         row_q;
    logic [7:0]         burst_q;
    logic [3:0]         clr_q;
    logic               fdone_q;
    logic [ROM_LAT-1:0] pipe_q;

    logic [7:0]         col_d;
    logic [7:0]         row_d;
    logic               w_col_wrap;
    logic               w_row_wrap;
    logic               w_frame_last;
    logic               w_next_last;
    logic               w_fifo_low;
    logic               w_strobe;
    logic               w_start;
    logic               w_stop_here;
    logic               w_burst_end;

    // Next scan position and the decodes that depend on it
    always_comb begin
        w_col_wrap   = (col_q == c_col_last);
        w_row_wrap   = (row_q == c_row_last);
        w_frame_last = w_col_wrap & w_row_wrap;
        col_d        = w_col_wrap ? 8'd0 : 8'(col_q + 8'd1);
        if (w_col_wrap) begin
            row_d = w_row_wrap ? 8'd0 : 8'(row_q + 8'd1);
        end else begin
            row_d = row_q;
        end
        w_next_last  = (col_d == c_col_last) & (row_d == c_row_last);
        w_fifo_low   = (fifo_used_i < c_fifo_low);
        w_strobe     = (state_q == WR_FIFO);
    end

`ifdef ROM_FRAME_STOP_EN
    logic armed_q;
    logic en_prev_q;

    // A rising edge of en_i both re-arms and may start a burst on the same edge
    assign w_start     = en_i & w_fifo_low & (armed_q | ~en_prev_q);
    assign w_stop_here = w_frame_last;

    // Disarm on the last pixel of a frame; re-arm on an en_i rising edge
    always_ff @(posedge clk_100M_i) begin
        if (!rst_100i) begin
            armed_q   <= 1'b1;
            en_prev_q <= 1'b0;
        end else begin
            en_prev_q <= en_i;
            if (w_strobe && w_frame_last) begin
                armed_q <= 1'b0;
            end else if (en_i && !en_prev_q) begin
                armed_q <= 1'b1;
            end
        end
    end
`else
    assign w_start     = en_i & w_fifo_low;
    assign w_stop_here = 1'b0;
`endif

    assign w_burst_end = (burst_q == c_burst_last) | w_stop_here;

    // Control FSM: clear wait, idle/level check, burst with address scan
    always_ff @(posedge clk_100M_i) begin
        if (!rst_100i) begin
            state_q <= CLEAR;
            clr_q   <= 4'd0;
            col_q   <= 8'd0;
            row_q   <= 8'd0;
            burst_q <= 8'd0;
            fdone_q <= 1'b0;
        end else begin
            fdone_q <= 1'b0;
            case (state_q)
                CLEAR: begin
                    if (clr_q == c_clear_last) begin
                        state_q <= IDLE;
                        clr_q   <= 4'd0;
                    end else begin
                        clr_q <= clr_q + 4'd1;
                    end
                end
                IDLE: begin
                    if (w_start) begin
                        state_q <= WR_FIFO;
                        burst_q <= 8'd0;
                        // First strobe of the burst uses the current address
                        fdone_q <= w_frame_last;
                    end
                end
                WR_FIFO: begin
                    col_q <= col_d;
                    row_q <= row_d;
                    if (w_burst_end) begin
                        state_q <= IDLE;
                        burst_q <= 8'd0;
                    end else begin
                        burst_q <= burst_q + 8'd1;
                        // Pulse aligns with the cycle that strobes the last pixel
                        fdone_q <= w_next_last;
                    end
                end
                default: begin
                    state_q <= CLEAR;
                    clr_q   <= 4'd0;
                end
            endcase
        end
    end

    // Read strobe delay line matching the ROM read latency
    generate
        if (ROM_LAT == 1) begin : g_pipe_single
            always_ff @(posedge clk_100M_i) begin
                if (!rst_100i) begin
                    pipe_q <= '0;
                end else begin
                    pipe_q <= w_strobe;
                end
            end
        end else begin : g_pipe_multi
            always_ff @(posedge clk_100M_i) begin
                if (!rst_100i) begin
                    pipe_q <= '0;
                end else begin
                    pipe_q <= {pipe_q[ROM_LAT-2:0], w_strobe};
                end
            end
        end
    endgenerate

    assign rdrom_add_o  = {row_q, col_q};
    assign fifo_dat_o   = rom_dat_i;
    assign wr_fifo_o    = pipe_q[ROM_LAT-1];
    assign frame_done_o = fdone_q;
    // Busy until the last in-flight strobe has reached the FIFO
    assign busy_o       = (state_q != IDLE) | (|pipe_q);

endmodule
`default_nettype wire

// File: tb/tb_rom_fifo_filler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rom_fifo_filler
//  Brief    : Directed bench for rom_fifo_filler. A small-geometry instance
//             is driven from a per-cycle vector table; a default-geometry
//             instance is driven by hand-written burst/reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rom_fifo_filler;

    logic        clk;
    logic [2:0]  rom_dat;

    // Default-geometry instance
    logic        rst_a;
    logic        en_a;
    logic [10:0] used_a;
    logic [15:0] addr_a;
    logic [2:0]  dat_a;
    logic        wr_a;
    logic        busy_a;
    logic        fd_a;

    // Small-geometry instance (4 x 2 frame, 10-word bursts)
    logic        rst_b;
    logic        en_b;
    logic [10:0] used_b;
    logic [15:0] addr_b;
    logic [2:0]  dat_b;
    logic        wr_b;
    logic        busy_b;
    logic        fd_b;

    int total = 0;
    int bad   = 0;

    rom_fifo_filler dut_a (
        .clk_100M_i   (clk),
        .rst_100i     (rst_a),
        .en_i         (en_a),
        .fifo_used_i  (used_a),
        .rom_dat_i    (rom_dat),
        .rdrom_add_o  (addr_a),
        .fifo_dat_o   (dat_a),
        .wr_fifo_o    (wr_a),
        .busy_o       (busy_a),
        .frame_done_o (fd_a)
    );

    rom_fifo_filler #(
        .H_ACT     (4),
        .V_ACT     (2),
        .BURST_LEN (10)
    ) dut_b (
        .clk_100M_i   (clk),
        .rst_100i     (rst_b),
        .en_i         (en_b),
        .fifo_used_i  (used_b),
        .rom_dat_i    (rom_dat),
        .rdrom_add_o  (addr_b),
        .fifo_dat_o   (dat_b),
        .wr_fifo_o    (wr_b),
        .busy_o       (busy_b),
        .frame_done_o (fd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        en;
        logic [10:0] used;
        logic [15:0] addr;
        logic        wr;
        logic        busy;
        logic        fd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic e, logic [10:0] u,
                                logic [15:0] a, logic w, logic b, logic f);
        vec_t t;
        t.rst_n = r; t.en = e; t.used = u;
        t.addr = a; t.wr = w; t.busy = b; t.fd = f;
        return t;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    initial begin
        rom_dat = 3'b000;
        rst_a = 1'b0; en_a = 1'b1; used_a = 11'd0;
        rst_b = 1'b0; en_b = 1'b1; used_b = 11'd0;

        // ---------------- vector table for the small instance ----------------
        tbl.push_back(mk(0, 1, 0, 16'h0000, 0, 1, 0));              // reset
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk(1, 1, 0, 16'h0000, 0, 1, 0));          // CLEAR
        tbl.push_back(mk(1, 1, 0, 16'h0000, 0, 0, 0));              // IDLE
        tbl.push_back(mk(1, 1, 0, 16'h0000, 0, 1, 0));              // burst
        tbl.push_back(mk(1, 1, 0, 16'h0001, 1, 1, 0));
        tbl.push_back(mk(1, 1, 0, 16'h0002, 1, 1, 0));
        tbl.push_back(mk(1, 1, 0, 16'h0003, 1, 1, 0));
        tbl.push_back(mk(1, 1, 0, 16'h0100, 1, 1, 0));              // line wrap
        tbl.push_back(mk(1, 1, 0, 16'h0101, 1, 1, 0));
        tbl.push_back(mk(1, 1, 0, 16'h0102, 1, 1, 0));
        tbl.push_back(mk(1, 1, 0, 16'h0103, 1, 1, 1));              // frame done
`ifdef ROM_FRAME_STOP_EN
        tbl.push_back(mk(1, 1, 0, 16'h0000, 1, 1, 0));              // truncated
        tbl.push_back(mk(1, 1, 0, 16'h0000, 0, 0, 0));              // disarmed
        tbl.push_back(mk(1, 1, 0, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0));              // en low
        tbl.push_back(mk(1, 1, 0, 16'h0000, 0, 1, 0));              // rise: resume
        tbl.push_back(mk(1, 1, 0, 16'h0001, 1, 1, 0));
`else
        tbl.push_back(mk(1, 1, 0, 16'h0000, 1, 1, 0));              // frame wrap
        tbl.push_back(mk(1, 1, 0, 16'h0001, 1, 1, 0));
        tbl.push_back(mk(1, 1, 512, 16'h0002, 1, 1, 0));            // burst over
        tbl.push_back(mk(1, 1, 512, 16'h0002, 0, 0, 0));            // level = LOW
        tbl.push_back(mk(1, 1, 512, 16'h0002, 0, 0, 0));
        tbl.push_back(mk(1, 1, 511, 16'h0002, 0, 1, 0));            // LOW-1 starts
        tbl.push_back(mk(1, 1, 511, 16'h0003, 1, 1, 0));
        tbl.push_back(mk(1, 0, 511, 16'h0100, 1, 1, 0));            // en drop ignored
        tbl.push_back(mk(1, 0, 511, 16'h0101, 1, 1, 0));
`endif

        foreach (tbl[i]) begin
            rst_b  = tbl[i].rst_n;
            en_b   = tbl[i].en;
            used_b = tbl[i].used;
            tick();
            chk($sformatf("vec%0d addr", i), 32'(addr_b), 32'(tbl[i].addr));
            chk($sformatf("vec%0d wr", i),   32'(wr_b),   32'(tbl[i].wr));
            chk($sformatf("vec%0d busy", i), 32'(busy_b), 32'(tbl[i].busy));
            chk($sformatf("vec%0d fdone", i), 32'(fd_b),  32'(tbl[i].fd));
        end

        // ---------------- data pass-through ----------------
        rom_dat = 3'b101;
        #1;
        chk("dat_pass_a 101", 32'(dat_a), 32'h5);
        chk("dat_pass_b 101", 32'(dat_b), 32'h5);
        rom_dat = 3'b010;
        #1;
        chk("dat_pass_a 010", 32'(dat_a), 32'h2);

        // ---------------- default instance: reset and CLEAR ----------------
        rst_a = 1'b0; en_a = 1'b1; used_a = 11'd0;
        tick();
        chk("a reset addr", 32'(addr_a), 32'h0);
        chk("a reset wr",   32'(wr_a),   32'h0);
        chk("a reset busy", 32'(busy_a), 32'h1);
        chk("a reset fd",   32'(fd_a),   32'h0);
        rst_a = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("a clear wr",   32'(wr_a),   32'h0);
            chk("a clear busy", 32'(busy_a), 32'h1);
        end
        tick();
        chk("a idle busy", 32'(busy_a), 32'h0);
        chk("a idle wr",   32'(wr_a),   32'h0);

        // ---------------- burst 1: 0x0000..0x00FE ----------------
        for (int k = 0; k < 255; k++) begin
            tick();
            chk("a b1 addr", 32'(addr_a), 32'(k));
            chk("a b1 wr",   32'(wr_a),   (k > 0) ? 32'h1 : 32'h0);
            chk("a b1 fd",   32'(fd_a),   32'h0);
            if (k == 254) used_a = 11'd512;
        end
        tick();
        chk("a b1 tail wr",   32'(wr_a),   32'h1);
        chk("a b1 tail addr", 32'(addr_a), 32'h00FF);
        chk("a b1 tail busy", 32'(busy_a), 32'h1);

        // ---------------- level at FIFO_LOW holds IDLE ----------------
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("a hold wr",   32'(wr_a),   32'h0);
            chk("a hold busy", 32'(busy_a), 32'h0);
            chk("a hold addr", 32'(addr_a), 32'h00FF);
        end
        used_a = 11'd511;

        // ---------------- burst 2: 0x00FF, 0x0100 .. 0x01FD ----------------
        for (int k = 0; k < 255; k++) begin
            tick();
            chk("a b2 addr", 32'(addr_a), 32'(255 + k));
            chk("a b2 wr",   32'(wr_a),   (k > 0) ? 32'h1 : 32'h0);
        end
        tick();
        chk("a b2 tail wr", 32'(wr_a), 32'h1);

        // ---------------- burst 3 interrupted by reset ----------------
        for (int k = 0; k <= 100; k++) begin
            tick();
            chk("a b3 addr", 32'(addr_a), 32'(16'h01FE + k));
        end
        rst_a = 1'b0;
        tick();
        chk("a midrst addr", 32'(addr_a), 32'h0);
        chk("a midrst wr",   32'(wr_a),   32'h0);
        chk("a midrst busy", 32'(busy_a), 32'h1);
        chk("a midrst fd",   32'(fd_a),   32'h0);
        rst_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("a post-rst wr",   32'(wr_a),   32'h0);
            chk("a post-rst addr", 32'(addr_a), 32'h0);
        end
        tick();
        chk("a restart addr0", 32'(addr_a), 32'h0);
        chk("a restart busy",  32'(busy_a), 32'h1);
        chk("a restart wr0",   32'(wr_a),   32'h0);
        tick();
        chk("a restart addr1", 32'(addr_a), 32'h1);
        chk("a restart wr1",   32'(wr_a),   32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rom_fifo_filler.md
Name: rom_fifo_filler

Overview:
- Write-side producer for the camera-to-SDRAM desk FIFO, running in the 100 MHz domain.
- Scans a pattern ROM by row and column counters.
- Issues ROM reads in fixed-length bursts whenever the FIFO write-side fill level drops below a low-water mark.
- Produces the delayed FIFO write request aligned with ROM read data; the 133 MHz SDRAM side drains the FIFO.

Parameters:
H_ACT, 256, columns per line (1..256); column counter wraps at H_ACT-1
V_ACT, 256, lines per frame (1..256); row counter wraps at V_ACT-1
BURST_LEN, 255, ROM reads issued per WR_FIFO visit (1..255)
FIFO_LOW, 512, burst starts only when fifo_used_i < FIFO_LOW
ROM_LAT, 1, ROM read latency in cycles (1..3); wr_fifo_o lags the read strobe by this amount
CLEAR_CYC, 8, cycles spent in CLEAR after reset (2..15)

Ports:
clk_100M_i  in  1  100 MHz clock, single clock domain
rst_100i  in  1  synchronous active-low reset
en_i  in  1  run enable, sampled in IDLE
fifo_used_i  in  11  FIFO write-side used words (wrusedw)
rom_dat_i  in  3  ROM read data, valid ROM_LAT cycles after address
rdrom_add_o  out  16  ROM address {row[7:0], col[7:0]}
fifo_dat_o  out  3  FIFO write data (combinational pass-through of rom_dat_i)
wr_fifo_o  out  1  FIFO wrreq, one word per high cycle
busy_o  out  1  high in CLEAR and WR_FIFO
frame_done_o  out  1  one-cycle pulse when last pixel of frame is read

Behaviour:
- Reset (rst_100i low at a rising edge): state=CLEAR, row=col=0, rdrom_add_o=0, wr_fifo_o=0, busy_o=1, frame_done_o=0, burst counter=0, delay pipeline flushed. A reset mid-burst drops all in-flight strobes; no wr_fifo_o pulse appears after reset.
- State encoding: CLEAR=2'b00, IDLE=2'b01, WR_FIFO=2'b10, NONE2=2'b11. NONE2 is illegal and goes to CLEAR on the next edge.
- CLEAR: counts CLEAR_CYC cycles so the FIFO aclr settles, then goes to IDLE. No ROM reads are issued in CLEAR.
- IDLE to WR_FIFO: when en_i=1 and fifo_used_i < FIFO_LOW, same edge. The comparison is unsigned 11-bit. fifo_used_i = FIFO_LOW does not start a burst.
- WR_FIFO: internal read strobe is high every cycle for exactly BURST_LEN cycles. rdrom_add_o presents the current {row,col} while the strobe is high. Counters advance on each strobe.
  - After the last strobe the block returns to IDLE. The earliest next burst starts on the following cycle.
  - en_i falling mid-burst does not stop the burst.
  - fifo_used_i is not re-checked mid-burst; FIFO_LOW leaves 2048-512 headroom so BURST_LEN words always fit.
- Addressing:
  - col increments per strobe; at col=H_ACT-1 it wraps to 0 and row increments.
  - At row=V_ACT-1 and col=H_ACT-1 both wrap to 0.
  - frame_done_o pulses on the cycle that last address is strobed.
  - Bursts span line and frame boundaries freely.
- wr_fifo_o: the read strobe delayed by ROM_LAT registers. fifo_dat_o=rom_dat_i, so data and wrreq are aligned at the FIFO.
- busy_o also stays high until the delay pipeline drains after WR_FIFO.
- Throughput: BURST_LEN words per burst plus 1 IDLE cycle, at minimum.

Optional Feature:
ROM_FRAME_STOP_EN:
- Defined: after frame_done_o the block is disarmed and stays in IDLE, even if fifo_used_i < FIFO_LOW.
  - It re-arms only on an en_i rising edge (en_i low for at least one cycle, then high).
  - The burst in which the frame wrapped is truncated at the wrap: the strobe stops after address {V_ACT-1,H_ACT-1}.
- Undefined: continuous looping over frames. Bursts are never truncated, and en_i is level-sensitive.

Test Plan:
1. Reset release, en_i=1, fifo_used_i=0 -> 8 CLEAR cycles with wr_fifo_o=0, busy_o=1; then addresses 0x0000..0x00FE on 255 consecutive cycles; wr_fifo_o high for 255 cycles, lagging the addresses by 1 cycle.
2. fifo_used_i=512 held, en_i=1 -> stays in IDLE, wr_fifo_o=0. Drop fifo_used_i to 511 -> burst starts on the next edge.
3. Second burst after burst 1 -> first address 0x00FF, then 0x0100 (row wrap), continuing to 0x01FD.
4. H_ACT=4, V_ACT=2, BURST_LEN=10 -> address sequence 0x0000..0x0003, 0x0100..0x0103, 0x0000, 0x0001; frame_done_o pulses once, with address 0x0103.
5. rst_100i low for 1 cycle at burst word 100 -> outputs zero on the next edge, no further wr_fifo_o pulses, restart from 0x0000 after CLEAR.
6. ROM_FRAME_STOP_EN defined, parameters as in 4 -> burst ends after 0x0103, idles with fifo_used_i=0. Pulse en_i 1->0->1 -> resumes at 0x0000.
